// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame constants,
// common command bytes and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        idle  = 3'd0,
        rts   = 3'd1,
        start = 3'd2,
        data  = 3'd3,
        stop  = 3'd4,
        done  = 3'd5
    } ps2_tx_state_e;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Host-side command and pad bundle for the PS/2 transmitter.
// master = host logic plus pad model, slave = ps2_tx.
interface ps2_tx_if;
    import ps2_pkg::*;

    logic                     wr_ps2;
    logic [PS2_DATA_BITS-1:0] din;
    logic                     ps2c_in;
    logic                     ps2d_in;
    logic                     ps2c_oe;
    logic                     ps2d_oe;
    logic                     tx_idle;
    logic                     tx_done_tick;
    logic                     err;

    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, err
    );

    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, err
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter: the filtered level moves only when all FILTER_LEN
// taps agree; fall_edge_o is a registered one-cycle pulse on filtered 1->0.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_i,
    output logic fall_edge_o
);

    logic [FILTER_LEN-1:0] taps_q;
    logic [FILTER_LEN-1:0] taps_d;
    logic                  filt_q;
    logic                  filt_d;
    logic                  fall_q;
    logic                  fall_d;

    // Shift in the pad sample and resolve the filtered level.
    always_comb begin
        taps_d = (taps_q << 1'b1) | FILTER_LEN'(ps2c_i);
        if (taps_q == {FILTER_LEN{1'b1}}) begin
            filt_d = 1'b1;
        end else if (taps_q == {FILTER_LEN{1'b0}}) begin
            filt_d = 1'b0;
        end else begin
            filt_d = filt_q;
        end
        fall_d = filt_q & ~filt_d;
    end

    // Filter taps, filtered level and edge pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taps_q <= {FILTER_LEN{1'b0}};
            filt_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            taps_q <= taps_d;
            filt_q <= filt_d;
            fall_q <= fall_d;
        end
    end

    assign fall_edge_o = fall_q;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then start/data/parity/stop
// on device clock falls. Define PS2_TX_ACK_CHECK_EN to flag a missing ack in err.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = 5000,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FILTER_LEN     = 8
) (
    input logic     clk,
    input logic     reset,
    ps2_tx_if.slave bus
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > RTS_CYCLES) ? TIMEOUT_CYCLES : RTS_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int NW      = $clog2(PS2_DATA_BITS + 1);

    localparam logic [CW-1:0] RTS_LOAD = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [NW-1:0] N_LOAD   = NW'(PS2_DATA_BITS);
    localparam logic [NW-1:0] N_ZERO   = {NW{1'b0}};

    ps2_tx_state_e            state_q;
    ps2_tx_state_e            state_d;
    logic [CW-1:0]            c_q;
    logic [CW-1:0]            c_d;
    logic [NW-1:0]            n_q;
    logic [NW-1:0]            n_d;
    logic [PS2_DATA_BITS:0]   b_q;
    logic [PS2_DATA_BITS:0]   b_d;
    logic                     err_q;
    logic                     err_d;
    logic                     ps2c_oe_q;
    logic                     ps2c_oe_d;
    logic                     ps2d_oe_q;
    logic                     ps2d_oe_d;
    logic                     tx_idle_q;
    logic                     tx_idle_d;
    logic                     tx_done_q;
    logic                     tx_done_d;
    logic                     fall_edge_s;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .ps2c_i      (bus.ps2c_in),
        .fall_edge_o (fall_edge_s)
    );

    // Next-state logic: frame sequencing, shift register and watchdog.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        n_d     = n_q;
        b_d     = b_q;
        err_d   = err_q;
        case (state_q)
            idle: begin
                if (bus.wr_ps2) begin
                    b_d     = {odd_parity(bus.din), bus.din};
                    err_d   = 1'b0;
                    c_d     = RTS_LOAD;
                    state_d = rts;
                end else begin
                    state_d = idle;
                end
            end
            rts: begin
                // Our own clock pull produces a filtered fall here; it is ignored.
                if (c_q == CNT_ZERO) begin
                    c_d     = TO_LOAD;
                    state_d = start;
                end else begin
                    c_d = c_q - 1'b1;
                end
            end
            start: begin
                if (fall_edge_s) begin
                    n_d     = N_LOAD;
                    c_d     = TO_LOAD;
                    state_d = data;
                end else if (c_q == CNT_ZERO) begin
                    err_d   = 1'b1;
                    state_d = done;
                end else begin
                    c_d = c_q - 1'b1;
                end
            end
            data: begin
                if (fall_edge_s) begin
                    b_d = {1'b1, b_q[PS2_DATA_BITS:1]};
                    c_d = TO_LOAD;
                    if (n_q == N_ZERO) begin
                        state_d = stop;
                    end else begin
                        n_d = n_q - 1'b1;
                    end
                end else if (c_q == CNT_ZERO) begin
                    err_d   = 1'b1;
                    state_d = done;
                end else begin
                    c_d = c_q - 1'b1;
                end
            end
            stop: begin
                if (fall_edge_s) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    if (bus.ps2d_in) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
`else
                    err_d = err_q;
`endif
                    state_d = done;
                end else if (c_q == CNT_ZERO) begin
                    err_d   = 1'b1;
                    state_d = done;
                end else begin
                    c_d = c_q - 1'b1;
                end
            end
            done: begin
                c_d     = CNT_ZERO;
                state_d = idle;
            end
            default: begin
                state_d = idle;
            end
        endcase
    end

    // Output decode from the next state so the pads come straight off flops.
    always_comb begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        tx_idle_d = 1'b0;
        tx_done_d = 1'b0;
        case (state_d)
            idle:    tx_idle_d = 1'b1;
            rts:     ps2c_oe_d = 1'b1;
            start:   ps2d_oe_d = 1'b1;
            data:    ps2d_oe_d = ~b_d[0];
            stop:    ps2d_oe_d = 1'b0;
            done:    tx_done_d = 1'b1;
            default: tx_idle_d = 1'b0;
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= idle;
            c_q       <= CNT_ZERO;
            n_q       <= N_ZERO;
            b_q       <= {(PS2_DATA_BITS + 1){1'b0}};
            err_q     <= 1'b0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            tx_idle_q <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            n_q       <= n_d;
            b_q       <= b_d;
            err_q     <= err_d;
            ps2c_oe_q <= ps2c_oe_d;
            ps2d_oe_q <= ps2d_oe_d;
            tx_idle_q <= tx_idle_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign bus.ps2c_oe      = ps2c_oe_q;
    assign bus.ps2d_oe      = ps2d_oe_q;
    assign bus.tx_idle      = tx_idle_q;
    assign bus.tx_done_tick = tx_done_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: open-drain pad model, device clock model and a
// scoreboard of expected frame bit patterns.
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int RTS  = 5000;
    localparam int TMO  = 10000;
    localparam int FL   = 8;
    localparam int HALF = 80;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic dev_c = 1'b1;
    logic dev_d = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [PS2_FRAME_BITS-1:0] sb[$];

    ps2_tx_if bus ();

    ps2_tx #(
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.ps2c_in = dev_c & ~bus.ps2c_oe;
    assign bus.ps2d_in = dev_d & ~bus.ps2d_oe;

    always @(negedge clk) begin
        if (bus.tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic logic [PS2_FRAME_BITS-1:0] frame_bits(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe wr_ps2, queue the expected frame and time the request-to-send.
    task automatic send(input logic [7:0] b, input logic [PS2_FRAME_BITS-1:0] pat);
        int cnt;
        @(negedge clk);
        bus.din    = b;
        bus.wr_ps2 = 1'b1;
        sb.push_back(pat);
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        cnt = 0;
        while (bus.ps2c_oe === 1'b1 && cnt < RTS + 100) begin
            cnt++;
            @(negedge clk);
        end
        check("rts_len", cnt, RTS);
        check("start_bit_oe", {31'd0, bus.ps2d_oe}, 32'd1);
        check("start_busy", {31'd0, bus.tx_idle}, 32'd0);
    endtask

    // Device clocking: sample data while clock is high, then pull it low.
    task automatic dev_frame(input int n_falls, input bit ack, input int inj_at,
                             input int rst_at, output logic [PS2_FRAME_BITS-1:0] samp);
        samp = '1;
        for (int k = 0; k < n_falls; k++) begin
            repeat (HALF) @(negedge clk);
            samp[k] = bus.ps2d_in;
            if (k == 10 && ack) dev_d = 1'b0;
            dev_c = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == inj_at) begin
                bus.din    = 8'h00;
                bus.wr_ps2 = 1'b1;
                @(negedge clk);
                bus.wr_ps2 = 1'b0;
            end
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_ps2c_oe", {31'd0, bus.ps2c_oe}, 32'd0);
                check("rst_ps2d_oe", {31'd0, bus.ps2d_oe}, 32'd0);
                check("rst_tx_idle", {31'd0, bus.tx_idle}, 32'd1);
                check("rst_err", {31'd0, bus.err}, 32'd0);
                @(negedge clk);
                reset = 1'b0;
            end
            dev_c = 1'b1;
            dev_d = 1'b1;
            if (k == rst_at) break;
        end
    endtask

    // Expect exactly one done pulse since d0, then an idle, released transmitter.
    task automatic finish_frame(input int d0, input logic exp_err);
        int w;
        w = 0;
        while (done_cnt == d0 && w < 200) begin
            w++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("done_ticks", done_cnt - d0, 32'd1);
        check("err", {31'd0, bus.err}, {31'd0, exp_err});
        check("idle_after", {31'd0, bus.tx_idle}, 32'd1);
        check("oe_released", {30'd0, bus.ps2c_oe, bus.ps2d_oe}, 32'd0);
    endtask

    initial begin
        logic [PS2_FRAME_BITS-1:0] s;
        logic [PS2_FRAME_BITS-1:0] e;
        int   w;
        int   d0;
        logic exp_noack;

        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ps2c_oe", {31'd0, bus.ps2c_oe}, 32'd0);
        check("reset_ps2d_oe", {31'd0, bus.ps2d_oe}, 32'd0);
        check("reset_tx_idle", {31'd0, bus.tx_idle}, 32'd1);
        check("reset_done", {31'd0, bus.tx_done_tick}, 32'd0);
        check("reset_err", {31'd0, bus.err}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // SET_LED with ack: literal expected pattern 0,1,0,1,1,0,1,1,1,1,1.
        d0 = done_cnt;
        send(PS2_CMD_SET_LED, 11'b111_1101_1010);
        dev_frame(11, 1'b1, -1, -1, s);
        e = sb.pop_front();
        check("frame_ed", s, e);
        finish_frame(d0, 1'b0);

        // 0xF4 with a second wr_ps2 (0x00) pulsed mid-data.
        d0 = done_cnt;
        send(8'hF4, frame_bits(8'hF4));
        dev_frame(11, 1'b1, 3, -1, s);
        e = sb.pop_front();
        check("frame_f4", s, e);
        check("f4_parity", {31'd0, s[9]}, 32'd0);
        finish_frame(d0, 1'b0);

        // Missing ack.
`ifdef PS2_TX_ACK_CHECK_EN
        exp_noack = 1'b1;
`else
        exp_noack = 1'b0;
`endif
        d0 = done_cnt;
        send(8'h55, frame_bits(8'h55));
        dev_frame(11, 1'b0, -1, -1, s);
        e = sb.pop_front();
        check("frame_noack", s, e);
        finish_frame(d0, exp_noack);

        // Device stops after start + 4 data bits; a 5-cycle glitch must not count.
        d0 = done_cnt;
        send(8'hA5, frame_bits(8'hA5));
        dev_frame(5, 1'b0, -1, -1, s);
        e = sb.pop_front();
        check("timeout_bits", {27'd0, s[4:0]}, {27'd0, e[4:0]});
        w = 0;
        while (done_cnt == d0 && w < TMO + 1000) begin
            if (w == 2000) dev_c = 1'b0;
            if (w == 2005) dev_c = 1'b1;
            w++;
            @(negedge clk);
        end
        check("timeout_window", {31'd0, (w >= TMO - HALF) && (w <= TMO - HALF + 2 * FL + 4)}, 32'd1);
        finish_frame(d0, 1'b1);

        // Reset in the middle of the data bits, then a normal RESET command.
        d0 = done_cnt;
        send(8'h3C, frame_bits(8'h3C));
        dev_frame(11, 1'b1, -1, 3, s);
        e = sb.pop_front();
        check("reset_frame_bits", {28'd0, s[3:0]}, {28'd0, e[3:0]});
        repeat (30) @(negedge clk);
        check("reset_no_done", done_cnt - d0, 32'd0);
        check("reset_idle", {31'd0, bus.tx_idle}, 32'd1);

        d0 = done_cnt;
        send(PS2_CMD_RESET, frame_bits(PS2_CMD_RESET));
        dev_frame(11, 1'b1, -1, -1, s);
        e = sb.pop_front();
        check("frame_ff", s, e);
        finish_frame(d0, 1'b0);

        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
